// File: rtl/riscv_test_monitor_pkg.sv
// Shared encodings for the riscv-tests monitor: FSM state codes and the default tohost address.
package riscv_test_monitor_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } mon_state_e;

  localparam logic [31:0] TOHOST_ADDR_DFLT = 32'h0000_1000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (en && (q != {W{1'b1}}))
      q <= q + W'(1);
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// Reset sequencer and tohost pass/fail/timeout monitor for riscv-tests runs.
// Optional MONITOR_RETIRE_CNT_EN adds a retire_count output counting retires in RUN.
module riscv_test_monitor
  import riscv_test_monitor_pkg::*;
#(
  parameter int                XLEN         = 32,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(TOHOST_ADDR_DFLT),
  parameter int                RESET_CYCLES = 2,
  parameter int                MAX_CYCLES   = 5000,
  parameter int                CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              retire,
  output logic              core_rst,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [XLEN-2:0]   fail_code,
  output logic [CNT_W-1:0]  cycle_count
`ifdef MONITOR_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_count
`endif
);

  localparam int HOLD_W = $clog2(RESET_CYCLES) + 1;

  mon_state_e        state, state_nx;
  logic [HOLD_W-1:0] hold_q;
  logic              in_hold, in_run, hit, hit_pass, hit_fail, at_limit;

  assign in_hold  = (state == ST_HOLD);
  assign in_run   = (state == ST_RUN);
  assign hit      = in_run && mem_we && (mem_addr == TOHOST_ADDR);
  assign hit_pass = hit && (mem_wdata == XLEN'(1));
  assign hit_fail = hit && mem_wdata[0] && (mem_wdata != XLEN'(1));
  assign at_limit = (cycle_count == CNT_W'(MAX_CYCLES - 1));

  sat_counter #(.W(HOLD_W)) u_hold (
    .clk (clk),
    .clr (rst),
    .en  (in_hold),
    .q   (hold_q)
  );

  // The increment on the verdict edge is kept, so a hit at run cycle N reads back N+1.
  sat_counter #(.W(CNT_W)) u_cycle (
    .clk (clk),
    .clr (rst),
    .en  (in_run),
    .q   (cycle_count)
  );

`ifdef MONITOR_RETIRE_CNT_EN
  sat_counter #(.W(CNT_W)) u_retire (
    .clk (clk),
    .clr (rst),
    .en  (in_run && retire),
    .q   (retire_count)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HOLD;
    else     state <= state_nx;
  end

  // A verdict-producing hit outranks the timeout boundary on the same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      ST_HOLD: if (hold_q == HOLD_W'(RESET_CYCLES - 1)) state_nx = ST_RUN;
      ST_RUN: begin
        if (hit_pass)      state_nx = ST_PASS;
        else if (hit_fail) state_nx = ST_FAIL;
        else if (at_limit) state_nx = ST_TIMEOUT;
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_rst  <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      fail_code <= '0;
    end else begin
      core_rst <= (state_nx != ST_RUN);
      done     <= (state_nx == ST_PASS) || (state_nx == ST_FAIL) || (state_nx == ST_TIMEOUT);
      pass     <= (state_nx == ST_PASS);
      fail     <= (state_nx == ST_FAIL);
      timeout  <= (state_nx == ST_TIMEOUT);
      if (in_run && hit_fail) fail_code <= mem_wdata[XLEN-1:1];
    end
  end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: stimulus queues expected snapshots, a negedge monitor checks them.
module tb_riscv_test_monitor;
  import riscv_test_monitor_pkg::*;

  localparam int XLEN  = 32;
  localparam int AW    = 32;
  localparam int CW    = 32;
  localparam int MAXC  = 100;
  localparam int RSTC  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mem_we = 1'b0;
  logic [AW-1:0]   mem_addr = '0;
  logic [XLEN-1:0] mem_wdata = '0;
  logic            retire = 1'b0;
  logic            core_rst, done, pass, fail, timeout;
  logic [XLEN-2:0] fail_code;
  logic [CW-1:0]   cycle_count;
`ifdef MONITOR_RETIRE_CNT_EN
  logic [CW-1:0]   retire_count;
`endif

  riscv_test_monitor #(
    .XLEN(XLEN), .ADDR_W(AW), .TOHOST_ADDR(AW'(TOHOST_ADDR_DFLT)),
    .RESET_CYCLES(RSTC), .MAX_CYCLES(MAXC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .retire(retire), .core_rst(core_rst), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .fail_code(fail_code), .cycle_count(cycle_count)
`ifdef MONITOR_RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  typedef struct {
    string           name;
    int unsigned     at;
    logic            crst, dn, ps, fl, to;
    logic [XLEN-2:0] fc;
    logic [CW-1:0]   cc;
    logic [CW-1:0]   rc;
  } exp_t;

  exp_t        sb[$];
  int unsigned rise_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        done_d = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks done-rise timing and any snapshot scheduled for this cycle.
  always @(negedge clk) begin
    int unsigned e;
    exp_t        x;
    logic [CW-1:0] rc_act;
    if (done && !done_d) begin
      n_cmp++;
      if (rise_q.size() == 0) begin
        n_bad++;
        $display("FAIL done_rise: rose at cycle %0d, no rise expected", cyc);
      end else begin
        e = rise_q.pop_front();
        if (e != cyc) begin
          n_bad++;
          $display("FAIL done_rise: rose at cycle %0d, required cycle %0d", cyc, e);
        end
      end
    end
    done_d = done;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      x = sb.pop_front();
`ifdef MONITOR_RETIRE_CNT_EN
      rc_act = retire_count;
`else
      rc_act = x.rc;
`endif
      n_cmp++;
      if (x.at != cyc || core_rst !== x.crst || done !== x.dn || pass !== x.ps ||
          fail !== x.fl || timeout !== x.to || fail_code !== x.fc ||
          cycle_count !== x.cc || rc_act !== x.rc) begin
        n_bad++;
        $display("FAIL %s: got crst=%b done=%b pass=%b fail=%b to=%b fc=%0d cc=%0d rc=%0d, need crst=%b done=%b pass=%b fail=%b to=%b fc=%0d cc=%0d rc=%0d",
                 x.name, core_rst, done, pass, fail, timeout, fail_code, cycle_count, rc_act,
                 x.crst, x.dn, x.ps, x.fl, x.to, x.fc, x.cc, x.rc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_st(input string name, input logic crst, input logic dn, input logic ps,
                           input logic fl, input logic to, input int fc, input int cc, input int rc);
    exp_t x;
    x.name = name; x.at = cyc; x.crst = crst; x.dn = dn; x.ps = ps; x.fl = fl; x.to = to;
    x.fc = (XLEN-1)'(fc); x.cc = CW'(cc); x.rc = CW'(rc);
    sb.push_back(x);
  endtask

  task automatic expect_rise_next();
    rise_q.push_back(cyc + 1);
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    tick();
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
  endtask

  // Reset for one edge, then two HOLD cycles before RUN at cycle_count 0.
  task automatic do_reset(input string tag);
    rst = 1'b1; mem_we = 1'b0; retire = 1'b0;
    tick();
    rst = 1'b0;
    expect_st({tag, "_hold0"}, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_st({tag, "_hold1"}, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_st({tag, "_run0"}, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset sequence and pass at run cycle 40
    do_reset("t1");
    ticks(20);
    expect_st("t2_mid", 0, 0, 0, 0, 0, 0, 20, 0);
    ticks(20);
    expect_rise_next();
    store(32'h0000_1000, 32'h1);
    expect_st("t2_pass", 1, 1, 1, 0, 0, 0, 41, 0);
    ticks(3);
    store(32'h0000_1000, 32'h7);
    expect_st("t2_frozen", 1, 1, 1, 0, 0, 0, 41, 0);

    // Fail with code 3; a later pass store is ignored
    do_reset("t3");
    ticks(5);
    expect_rise_next();
    store(32'h0000_1000, 32'h7);
    expect_st("t3_fail", 1, 1, 0, 1, 0, 3, 6, 0);
    store(32'h0000_1000, 32'h1);
    expect_st("t3_sticky", 1, 1, 0, 1, 0, 3, 6, 0);

    // Fail with a large odd code
    do_reset("t3b");
    expect_rise_next();
    store(32'h0000_1000, 32'hFFFF_FFFF);
    expect_st("t3b_fail", 1, 1, 0, 1, 0, 32'h7FFF_FFFF, 1, 0);

    // Non-hits, then timeout at run cycle 100
    do_reset("t4");
    ticks(3);
    store(32'h0000_1004, 32'h1);
    expect_st("t4_wrong_addr", 0, 0, 0, 0, 0, 0, 4, 0);
    tick();
    store(32'h0000_1000, 32'h2);
    expect_st("t4_even_data", 0, 0, 0, 0, 0, 0, 6, 0);
    store(32'h8000_1000, 32'h1);
    expect_st("t4_high_addr", 0, 0, 0, 0, 0, 0, 7, 0);
    ticks(92);
    expect_st("t4_limit", 0, 0, 0, 0, 0, 0, 99, 0);
    expect_rise_next();
    tick();
    expect_st("t4_timeout", 1, 1, 0, 0, 1, 0, 100, 0);
    store(32'h0000_1000, 32'h1);
    expect_st("t4_sticky", 1, 1, 0, 0, 1, 0, 100, 0);

    // Hit on the timeout boundary wins
    do_reset("t5");
    ticks(99);
    expect_rise_next();
    store(32'h0000_1000, 32'h1);
    expect_st("t5_boundary", 1, 1, 1, 0, 0, 0, 100, 0);

    // Reset after pass clears everything; retire counting in RUN
    do_reset("t6");
    for (int i = 0; i < 10; i++) begin
      retire = 1'b1; tick();
      retire = 1'b0; tick();
    end
    expect_st("t6_retire", 0, 0, 0, 0, 0, 0, 20, 10);
    expect_rise_next();
    store(32'h0000_1000, 32'h1);
    expect_st("t6_pass", 1, 1, 1, 0, 0, 0, 21, 10);
    retire = 1'b1; ticks(2); retire = 1'b0;
    expect_st("t6_frozen", 1, 1, 1, 0, 0, 0, 21, 10);

    // Mid-run reset from RUN without a verdict
    do_reset("t7");
    ticks(10);
    do_reset("t7b");

    ticks(3);
    n_cmp++;
    if (sb.size() != 0 || rise_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d snapshots and %0d rises left, need 0 and 0", sb.size(), rise_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
